// File: rtl/c2_pkg.sv
// c2_pkg -- shared types and constants for the C2 UART transmit path.
//   tx_fsm_e          : read-side FSM states of uart_tx_fifo
//   C2_TX_FIFO_DEPTH  : default transmit FIFO depth (entries)
//   byte_t            : one UART payload byte
package c2_pkg;

  localparam int unsigned C2_TX_FIFO_DEPTH = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } tx_fsm_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if -- byte write channel from the C2 TX mux plus the
// transceiver launch channel, seen from the FIFO (slave) and from the
// surrounding logic (master).
//   wr_data/wr_start/wr_done          : producer byte write handshake
//   phy_tx_data/phy_tx_start          : byte and launch pulse to the PHY
//   phy_tx_busy/phy_tx_done           : PHY status back to the FIFO
interface uart_tx_fifo_if;

  logic [7:0] wr_data;
  logic       wr_start;
  logic       wr_done;
  logic [7:0] phy_tx_data;
  logic       phy_tx_start;
  logic       phy_tx_busy;
  logic       phy_tx_done;

  modport master (
    output wr_data, wr_start, phy_tx_busy, phy_tx_done,
    input  wr_done, phy_tx_data, phy_tx_start
  );

  modport slave (
    input  wr_data, wr_start, phy_tx_busy, phy_tx_done,
    output wr_done, phy_tx_data, phy_tx_start
  );

endinterface

// File: rtl/c2_byte_fifo.sv
// c2_byte_fifo -- generic synchronous byte FIFO.
//   clk/rst     : clock, asynchronous active-high reset
//   flush       : synchronous clear of pointers and flags
//   push/push_data : write request and byte (ignored while full)
//   pop/head    : read request and current head byte (ignored while empty)
//   full/empty  : registered status flags
//   level       : occupied entries, 0..DEPTH
// DEPTH must be a power of two, at least 4.
module c2_byte_fifo
  import c2_pkg::*;
#(
  parameter int unsigned DEPTH = C2_TX_FIFO_DEPTH,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  byte_t            push_data,
  input  logic             pop,
  output byte_t            head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [AW:0] count_next;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // One extra pointer bit keeps write-minus-read exact at DEPTH while the
  // low bits index the storage modulo DEPTH.
  assign count = wr_ptr - rd_ptr;

  always_comb begin
    count_next = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign level = LVL_W'(count);

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- transmit FIFO between the C2 arbiter TX mux and the UART
// transceiver. Buffers bytes, holds one extra byte in a pending register
// when the FIFO is full, and launches one frame at a time to the PHY.
//   clk_i/rst_i : clock, asynchronous active-high reset
//   flush_i     : synchronous clear (soft reset); an in-flight frame completes
//   bus         : slave side of uart_tx_fifo_if (write + PHY channels)
//   full_o/empty_o/level_o : registered FIFO status
//   overflow_o  : sticky, a write arrived while the pending register was busy
module uart_tx_fifo
  import c2_pkg::*;
#(
  parameter int unsigned DEPTH = C2_TX_FIFO_DEPTH,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  uart_tx_fifo_if.slave     bus,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              overflow_o
);

  tx_fsm_e state;
  tx_fsm_e state_next;

  logic  pend_valid;
  byte_t pend_data;
  logic  pend_load;
  logic  drop;
  logic  wr_done_q;
  logic  ovf_q;
  byte_t tx_data_q;
  logic  tx_start;

  logic  fifo_push;
  byte_t fifo_push_data;
  logic  fifo_pop;
  byte_t fifo_head;
  logic  fifo_full;
  logic  fifo_empty;

  c2_byte_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

  // Write path. A parked byte always drains before any new request, so
  // ordering is preserved; a request seen while a byte is parked is lost,
  // even on the edge where the parked byte drains. The full flag is the
  // pre-edge value, so a pop and write on a full FIFO park the write and
  // commit it one edge later.
  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = bus.wr_data;
    pend_load      = 1'b0;
    drop           = 1'b0;
    if (!flush_i) begin
      if (pend_valid) begin
        if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = pend_data;
        end
        if (bus.wr_start) drop = 1'b1;
      end else if (bus.wr_start) begin
        if (!fifo_full) fifo_push = 1'b1;
        else            pend_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      wr_done_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_done_q <= fifo_push;
      if (flush_i) begin
        pend_valid <= 1'b0;
        pend_data  <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (pend_load) begin
          pend_valid <= 1'b1;
          pend_data  <= bus.wr_data;
        end else if (pend_valid && !fifo_full) begin
          pend_valid <= 1'b0;
        end
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  // Read FSM. Flush does not touch the state, so a frame already handed to
  // the PHY runs to completion; popping is suppressed on the flush edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      tx_data_q <= '0;
    end else begin
      state <= state_next;
      if (fifo_pop) tx_data_q <= fifo_head;
    end
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    tx_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !bus.phy_tx_busy && !flush_i) begin
          fifo_pop   = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tx_start   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.phy_tx_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.wr_done      = wr_done_q;
  assign bus.phy_tx_data  = tx_data_q;
  assign bus.phy_tx_start = tx_start;
  assign full_o           = fifo_full;
  assign empty_o          = fifo_empty;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- self-checking bench for uart_tx_fifo.
// Directed scenarios plus a randomized stream; expected bytes come from a
// queue-based reference and a simple PHY model that logs launched bytes.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;

  logic phy_auto;
  logic d_busy, d_done;
  logic m_busy, m_done;
  int unsigned hold_errs;
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_q[$];

  int unsigned n_checks;
  int unsigned n_errs;

  uart_tx_fifo_if bus ();

  assign bus.phy_tx_busy = phy_auto ? m_busy : d_busy;
  assign bus.phy_tx_done = phy_auto ? m_done : d_done;

  uart_tx_fifo #(
    .DEPTH (16),
    .LVL_W (5)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .bus        (bus),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // PHY model: logs each launched byte, stays busy for a random time, then
  // pulses done once the FIFO is waiting; flags any data change meanwhile.
  initial begin
    logic [7:0] held;
    m_busy    = 1'b0;
    m_done    = 1'b0;
    hold_errs = 0;
    forever begin
      @(negedge clk);
      if (phy_auto && !rst && bus.phy_tx_start) begin
        held = bus.phy_tx_data;
        tx_log.push_back(held);
        m_busy = 1'b1;
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          if (bus.phy_tx_data !== held) hold_errs++;
        end
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input string tag);
    bus.wr_data  = d;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check(tag, 32'(bus.wr_done), 32'd1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int cyc = 0;
    while (tx_log.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    check("drain_count", 32'(tx_log.size()), 32'(n));
    repeat (10) step();
  endtask

  task automatic compare_log(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tx_log.size()) check(tag, 32'(tx_log[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int starts;
    int occ;
    int unsigned n_wr;
    logic wrote;
    logic [7:0] d;

    n_checks     = 0;
    n_errs       = 0;
    phy_auto     = 1'b0;
    d_busy       = 1'b0;
    d_done       = 1'b0;
    flush        = 1'b0;
    bus.wr_data  = 8'h00;
    bus.wr_start = 1'b0;
    rst          = 1'b1;
    repeat (3) step();

    check("rst_empty",    32'(empty),            32'd1);
    check("rst_full",     32'(full),             32'd0);
    check("rst_level",    32'(level),            32'd0);
    check("rst_overflow", 32'(overflow),         32'd0);
    check("rst_start",    32'(bus.phy_tx_start), 32'd0);
    check("rst_data",     32'(bus.phy_tx_data),  32'h00);
    check("rst_wr_done",  32'(bus.wr_done),      32'd0);

    // Single byte, first write on the first edge after reset release.
    rst          = 1'b0;
    bus.wr_data  = 8'hA5;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check("single_wr_done", 32'(bus.wr_done),      32'd1);
    check("single_no_start_c1", 32'(bus.phy_tx_start), 32'd0);
    check("single_level",   32'(level),            32'd1);
    step();
    check("single_start",   32'(bus.phy_tx_start), 32'd1);
    check("single_data",    32'(bus.phy_tx_data),  32'hA5);
    check("single_empty",   32'(empty),            32'd1);
    check("single_wr_done_off", 32'(bus.wr_done),  32'd0);
    step();
    check("single_start_off", 32'(bus.phy_tx_start), 32'd0);
    check("single_hold",    32'(bus.phy_tx_data),  32'hA5);
    d_done = 1'b1;
    step();
    d_done = 1'b0;

    // Fill, park one byte, overflow one byte, then release.
    d_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i), "fill_wr_done");
    check("fill_full",  32'(full),  32'd1);
    check("fill_level", 32'(level), 32'd16);
    bus.wr_data  = 8'h10;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check("pend_no_wr_done", 32'(bus.wr_done), 32'd0);
    check("pend_level",      32'(level),       32'd16);
    bus.wr_data  = 8'h55;
    bus.wr_start = 1'b1;
    step();
    bus.wr_start = 1'b0;
    check("ovf_no_wr_done", 32'(bus.wr_done), 32'd0);
    check("ovf_flag",       32'(overflow),    32'd1);
    d_busy = 1'b0;
    step();
    check("rel_start",   32'(bus.phy_tx_start), 32'd1);
    check("rel_data",    32'(bus.phy_tx_data),  32'h00);
    check("rel_level",   32'(level),            32'd15);
    check("rel_no_done", 32'(bus.wr_done),      32'd0);
    step();
    check("pend_wr_done", 32'(bus.wr_done), 32'd1);
    check("pend_commit",  32'(level),       32'd16);
    check("pend_full",    32'(full),        32'd1);
    d_done = 1'b1;
    step();
    d_done = 1'b0;
    tx_log.delete();
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    phy_auto = 1'b1;
    wait_log(16, 2000);
    compare_log("fill_order");
    check("fill_drained", 32'(level),    32'd0);
    check("ovf_sticky",   32'(overflow), 32'd1);

    // Flush clears overflow; flush beats a same-cycle write.
    phy_auto = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ovf_clr", 32'(overflow), 32'd0);
    check("flush_empty",   32'(empty),    32'd1);
    flush        = 1'b1;
    bus.wr_data  = 8'h77;
    bus.wr_start = 1'b1;
    step();
    flush        = 1'b0;
    bus.wr_start = 1'b0;
    check("flushwr_no_done", 32'(bus.wr_done), 32'd0);
    check("flushwr_no_ovf",  32'(overflow),    32'd0);
    check("flushwr_level",   32'(level),       32'd0);
    step();
    check("flushwr_no_start", 32'(bus.phy_tx_start), 32'd0);

    // Simultaneous pop and write at level 5.
    d_busy = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i), "sim_fill");
    bus.wr_data  = 8'h26;
    bus.wr_start = 1'b1;
    d_busy       = 1'b0;
    step();
    bus.wr_start = 1'b0;
    check("sim_level",   32'(level),            32'd5);
    check("sim_wr_done", 32'(bus.wr_done),      32'd1);
    check("sim_start",   32'(bus.phy_tx_start), 32'd1);
    check("sim_data",    32'(bus.phy_tx_data),  32'h20);
    step();
    d_done = 1'b1;
    step();
    d_done = 1'b0;
    tx_log.delete();
    exp_q.delete();
    exp_q.push_back(8'h21); exp_q.push_back(8'h22); exp_q.push_back(8'h23);
    exp_q.push_back(8'h24); exp_q.push_back(8'h26);
    phy_auto = 1'b1;
    wait_log(5, 500);
    compare_log("sim_order");

    // Flush while a frame is in flight.
    phy_auto = 1'b0;
    d_busy   = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(8'h30 + 8'(i), "mid_fill");
    d_busy = 1'b0;
    step();
    d_busy = 1'b1;
    check("mid_start", 32'(bus.phy_tx_start), 32'd1);
    step();
    check("mid_level", 32'(level), 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mid_flush_level", 32'(level),           32'd0);
    check("mid_flush_empty", 32'(empty),           32'd1);
    check("mid_flush_hold",  32'(bus.phy_tx_data), 32'h30);
    d_done = 1'b1;
    step();
    d_done = 1'b0;
    d_busy = 1'b0;
    starts = 0;
    repeat (6) begin
      step();
      if (bus.phy_tx_start) starts++;
    end
    check("mid_no_restart", 32'(starts), 32'd0);

    // Asynchronous reset during S_LAUNCH.
    d_busy = 1'b1;
    write_byte(8'h40, "ar_fill");
    write_byte(8'h41, "ar_fill");
    d_busy = 1'b0;
    step();
    check("ar_start_before", 32'(bus.phy_tx_start), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("ar_start",   32'(bus.phy_tx_start), 32'd0);
    check("ar_data",    32'(bus.phy_tx_data),  32'h00);
    check("ar_level",   32'(level),            32'd0);
    check("ar_empty",   32'(empty),            32'd1);
    check("ar_full",    32'(full),             32'd0);
    check("ar_wr_done", 32'(bus.wr_done),      32'd0);
    starts = 0;
    repeat (2) begin
      step();
      if (bus.phy_tx_start) starts++;
    end
    rst = 1'b0;
    repeat (4) begin
      step();
      if (bus.phy_tx_start) starts++;
    end
    check("ar_no_start", 32'(starts), 32'd0);

    // Randomized stream, kept below full so every write is accepted.
    tx_log.delete();
    exp_q.delete();
    phy_auto = 1'b1;
    n_wr     = 0;
    for (int unsigned c = 0; c < 1500; c++) begin
      occ   = int'(n_wr) - tx_log.size();
      wrote = ($urandom_range(0, 2) == 0) && (occ < DEPTH - 1);
      if (wrote) begin
        d            = 8'($urandom_range(0, 255));
        bus.wr_data  = d;
        bus.wr_start = 1'b1;
        exp_q.push_back(d);
        n_wr++;
      end else begin
        bus.wr_start = 1'b0;
      end
      step();
      check("rnd_wr_done", 32'(bus.wr_done), 32'(wrote));
    end
    bus.wr_start = 1'b0;
    wait_log(exp_q.size(), 4000);
    compare_log("rnd_order");
    check("rnd_level", 32'(level), 32'd0);
    check("rnd_empty", 32'(empty), 32'd1);
    check("phy_data_hold", 32'(hold_errs), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, at least 4.
REQ-002 Parameter LVL_W, default $clog2(DEPTH)+1, width of level_o.
REQ-003 clk_i  in  1  sole clock; all state SHALL be on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 flush_i  in  1  synchronous clear, driven from the C2 soft reset.
REQ-006 wr_data_i  in  8  byte from the C2 TX mux.
REQ-007 wr_start_i  in  1  one-cycle write request, qualifying wr_data_i.
REQ-008 wr_done_o  out  1  one-cycle pulse: byte accepted into the FIFO.
REQ-009 phy_tx_data_o  out  8  registered byte to the UART transceiver.
REQ-010 phy_tx_start_o  out  1  one-cycle launch pulse to the transceiver.
REQ-011 phy_tx_busy_i  in  1  transceiver busy.
REQ-012 phy_tx_done_i  in  1  transceiver end-of-frame pulse.
REQ-013 full_o, empty_o  out  1 each  FIFO status, registered.
REQ-014 level_o  out  LVL_W  occupied entries, 0..DEPTH.
REQ-015 overflow_o  out  1  sticky error flag: a request was lost.

Function
REQ-016 Write path, full versus not full:
- When wr_start_i is sampled with level below DEPTH, the byte SHALL be stored at that edge.
- wr_done_o SHALL pulse in the following cycle.
REQ-017 Write path, full FIFO:
- When wr_start_i is sampled while full, the byte SHALL be latched in a one-entry pending register.
- It SHALL be stored on the first edge where space exists, with wr_done_o pulsing one cycle later.
REQ-018 Overflow: wr_start_i arriving while the pending register is occupied SHALL be dropped, set overflow_o, and produce no wr_done_o.
REQ-019 Simultaneous pop and write:
- Non-full FIFO: both SHALL complete in the same cycle and level_o is unchanged.
- Full FIFO: the write SHALL go to pending and be committed on the next edge.
REQ-020 Pointers SHALL wrap modulo DEPTH; level_o SHALL equal the write count minus the read count, with no wrap error at DEPTH.
REQ-021 Read FSM states: S_IDLE, S_LAUNCH, S_WAIT.
REQ-022 S_IDLE to S_LAUNCH when not empty and phy_tx_busy_i is low:
- pop the head into phy_tx_data_o at the same edge.
REQ-023 S_LAUNCH: phy_tx_start_o SHALL be high for exactly this one cycle, then go to S_WAIT.
REQ-024 S_WAIT to S_IDLE on phy_tx_done_i; phy_tx_data_o SHALL hold stable through S_WAIT.
REQ-025 Latency: a byte written into an empty FIFO, with the PHY idle and wr_start_i sampled at edge 0, SHALL have phy_tx_start_o high in cycle 2.
REQ-026 Back-to-back: with data queued, the next S_LAUNCH SHALL begin two cycles after phy_tx_done_i, provided phy_tx_busy_i is low.
REQ-027 flush_i SHALL:
- clear the pointers, level and pending register;
- clear overflow_o;
- discard pending bytes without wr_done_o.
REQ-028 flush_i in S_LAUNCH or S_WAIT SHALL NOT abort the frame; the FSM SHALL finish in S_WAIT and then idle on an empty FIFO.
REQ-029 flush_i and wr_start_i in the same cycle: flush SHALL win and the byte SHALL be dropped with no wr_done_o and no overflow.
REQ-030 phy_tx_done_i outside S_WAIT SHALL be ignored.

Reset
REQ-031 Asserting rst_i SHALL immediately force:
- FSM to S_IDLE;
- pointers, level_o and pending register to 0;
- wr_done_o, phy_tx_start_o and overflow_o to 0;
- phy_tx_data_o to 8'h00;
- empty_o to 1 and full_o to 0.
REQ-032 Reset mid-frame SHALL abandon the frame; no phy_tx_start_o SHALL occur while rst_i is high.
REQ-033 The first write SHALL be accepted on the first edge after rst_i deasserts.

Structure
REQ-034 Package c2_pkg SHALL hold the tx_fsm_e enum (S_IDLE, S_LAUNCH, S_WAIT) and the constant C2_TX_FIFO_DEPTH = 16.
REQ-035 Storage SHALL be the sub-module c2_byte_fifo, a generic synchronous FIFO with push, pop, full, empty and level.
- uart_tx_fifo SHALL contain the pending register, the FSM and the flags.
REQ-036 Integration: the block SHALL be inserted between the C2 arbiter TX mux and the UART transceiver.
- The producers' tx_done SHALL be driven from wr_done_o.

Verification
REQ-037 Single byte: after reset, write 8'hA5 at cycle 0 with the PHY idle -> wr_done_o in cycle 1, phy_tx_start_o in cycle 2 with data 8'hA5, empty_o=1 after the pop.
REQ-038 Fill: hold busy high and write 16 bytes 0x00..0x0F -> full_o=1 and level_o=16; a 17th byte 0x10 goes to pending with no wr_done_o.
- Release busy and pulse done -> 0x10 accepted, its wr_done_o pulses, output order 0x00..0x10.
REQ-039 Overflow: with full and pending occupied, write 0x55 -> overflow_o=1, 0x55 is never transmitted, and flush_i clears the flag.
REQ-040 Simultaneous: level 5 with a write and a pop in the same cycle -> level_o stays 5 and the write is acknowledged.
REQ-041 Flush mid-frame: in S_WAIT with 3 queued, assert flush_i -> no further start after phy_tx_done_i, level_o=0.
REQ-042 Async reset: assert rst_i between clock edges during S_LAUNCH -> outputs take their reset values before the next edge, with no glitched start.
